// File: rtl/pulse_train_pkg.sv
// Shared types and constants for the pulse train generator.
// Optional start delay is enabled by defining PULSE_TRAIN_DELAY_EN.
package pulse_train_pkg;

    localparam int PT_DEFAULT_WIDTH = 8;
    localparam int PT_RESET_COUNT   = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HIGH  = 3'd1,
        ST_LOW   = 3'd2,
        ST_DONE  = 3'd3
`ifdef PULSE_TRAIN_DELAY_EN
        ,
        ST_DELAY = 3'd4
`endif
    } pt_state_e;

endpackage

// File: rtl/pulse_train_gen_timer.sv
// Phase length down-counter shared by the timed states of pulse_train_gen.
// A zero length is stretched to one cycle; the counter parks at zero.
module pulse_phase_timer
    import pulse_train_pkg::*;
#(
    parameter int WIDTH = PT_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] length,
    output logic             expire
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: reload on phase entry, otherwise count down without wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = (length == '0) ? ONE : length;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == ONE);

endmodule

// File: rtl/pulse_train_gen.sv
// Counted pulse train generator: IDLE -> HIGH/LOW alternation -> DONE.
// Defining PULSE_TRAIN_DELAY_EN adds delay_cycles and a DELAY state before the first pulse.
module pulse_train_gen
    import pulse_train_pkg::*;
#(
    parameter int WIDTH = PT_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [WIDTH-1:0] load_count,
    input  logic [WIDTH-1:0] high_cycles,
    input  logic [WIDTH-1:0] low_cycles,
`ifdef PULSE_TRAIN_DELAY_EN
    input  logic [WIDTH-1:0] delay_cycles,
`endif
    output logic             out_pulse,
    output logic [WIDTH-1:0] remaining,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] RST_N = WIDTH'(PT_RESET_COUNT);

    pt_state_e        state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic [WIDTH-1:0] low_q, low_d;
    logic             out_q, out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tmr_load;
    logic [WIDTH-1:0] tmr_len;
    logic             tmr_expire;
`ifdef PULSE_TRAIN_DELAY_EN
    logic [WIDTH-1:0] dly_q, dly_d;
`endif

    pulse_phase_timer #(.WIDTH(WIDTH)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .length (tmr_len),
        .expire (tmr_expire)
    );

    // Next state, configuration capture and registered-output decode.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        high_d   = high_q;
        low_d    = low_q;
        tmr_load = 1'b0;
        tmr_len  = high_q;
`ifdef PULSE_TRAIN_DELAY_EN
        dly_d    = dly_q;
`endif
        if (!run) begin
            // Dropping run both aborts a train and keeps configuration tracking the inputs.
            state_d = ST_IDLE;
            rem_d   = load_count;
            high_d  = high_cycles;
            low_d   = low_cycles;
`ifdef PULSE_TRAIN_DELAY_EN
            dly_d   = delay_cycles;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rem_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
`ifdef PULSE_TRAIN_DELAY_EN
                        state_d  = ST_DELAY;
                        tmr_load = 1'b1;
                        tmr_len  = dly_q;
`else
                        state_d  = ST_HIGH;
                        tmr_load = 1'b1;
                        tmr_len  = high_q;
`endif
                    end
                end
                ST_HIGH: begin
                    if (tmr_expire) begin
                        rem_d = (rem_q != '0) ? (rem_q - ONE) : '0;
                        if (rem_q <= ONE) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d  = ST_LOW;
                            tmr_load = 1'b1;
                            tmr_len  = low_q;
                        end
                    end else begin
                        state_d = ST_HIGH;
                    end
                end
                ST_LOW: begin
                    if (tmr_expire) begin
                        state_d  = ST_HIGH;
                        tmr_load = 1'b1;
                        tmr_len  = high_q;
                    end else begin
                        state_d = ST_LOW;
                    end
                end
`ifdef PULSE_TRAIN_DELAY_EN
                ST_DELAY: begin
                    if (tmr_expire) begin
                        state_d  = ST_HIGH;
                        tmr_load = 1'b1;
                        tmr_len  = high_q;
                    end else begin
                        state_d = ST_DELAY;
                    end
                end
`endif
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        out_d  = (state_d == ST_HIGH);
        done_d = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    end

    // State, configuration and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= RST_N;
            high_q  <= ONE;
            low_q   <= ONE;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PULSE_TRAIN_DELAY_EN
            dly_q   <= ONE;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            high_q  <= high_d;
            low_q   <= low_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef PULSE_TRAIN_DELAY_EN
            dly_q   <= dly_d;
`endif
        end
    end

    assign out_pulse = out_q;
    assign remaining = rem_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
